isa_test_monitor: RTL

Parametrised, synthesizable ISA-test monitor for the RISC-V cores. Watches the core's debug PC and the LED output port, captures a character each time the program reaches the print routine, and buffers characters in a first-word-fall-through FIFO for a bench or UART to drain. Detects pass, fail and timeout as explicit terminal states. Replaces the sim-only single-cycle checker and also works with pipelined cores, where the PC can hold for several cycles.

---
 rtl/isa_test_monitor_if.sv | 69 ++++++
 rtl/isa_test_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/isa_test_monitor_if.sv
// ---------------------------------------------------------------------------
// isa_test_monitor_if
//   Bundles the core-facing and drain-facing signals of isa_test_monitor.
//   The clock and the active-low reset stay plain module ports.
//
//   Core side (into the monitor):
//     i_en        start monitoring (level)
//     i_pc_debug  core debug PC
//     i_io_ledr   LED port, character taken from [CHAR_W-1:0]
//   Drain side:
//     i_rd_en     pop the FIFO head
//     o_char      FIFO head, valid while o_char_vld
//     o_char_vld  FIFO non-empty
//     o_overflow  sticky, a character was dropped
//   Status:
//     o_state     IDLE=0 RUN=1 PASS=2 FAIL=3 TIMEOUT=4
//     o_done      state is PASS, FAIL or TIMEOUT
//     o_char_cnt  characters accepted into the FIFO, saturating
//     o_cycle_cnt cycles spent in RUN, saturating
//
//   Modports: slave is the monitor's view, master is the driver's view.
// ---------------------------------------------------------------------------
interface isa_test_monitor_if #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned CHAR_W = 8
) ();

    logic              i_en;
    logic [PC_W-1:0]   i_pc_debug;
    logic [31:0]       i_io_ledr;
    logic              i_rd_en;

    logic [CHAR_W-1:0] o_char;
    logic              o_char_vld;
    logic              o_overflow;
    logic [2:0]        o_state;
    logic              o_done;
    logic [15:0]       o_char_cnt;
    logic [31:0]       o_cycle_cnt;

    modport slave (
        input  i_en,
        input  i_pc_debug,
        input  i_io_ledr,
        input  i_rd_en,
        output o_char,
        output o_char_vld,
        output o_overflow,
        output o_state,
        output o_done,
        output o_char_cnt,
        output o_cycle_cnt
    );

    modport master (
        output i_en,
        output i_pc_debug,
        output i_io_ledr,
        output i_rd_en,
        input  o_char,
        input  o_char_vld,
        input  o_overflow,
        input  o_state,
        input  o_done,
        input  o_char_cnt,
        input  o_cycle_cnt
    );

endinterface

// File: rtl/isa_test_monitor.sv
// ---------------------------------------------------------------------------
// isa_test_monitor
//   Watches a RISC-V core's debug PC while an ISA test runs. Each arrival at
//   the print routine captures the low CHAR_W bits of the LED port into a
//   first-word-fall-through FIFO; reaching the end-of-test PC, the failure
//   trap or the cycle limit moves the monitor into a terminal state that is
//   held until reset. Works with pipelined cores where the PC may stall on
//   the print routine for several cycles (EDGE_MODE=1).
//
//   Ports:
//     i_clk    clock, all state updates on the rising edge
//     i_reset  asynchronous, active-low reset
//     bus      isa_test_monitor_if.slave (PC/LED inputs, FIFO drain, status)
//
//   Parameters:
//     PC_W        PC width
//     CHAR_W      captured character width (<= 32)
//     BUF_DEPTH   FIFO depth, power of two, >= 2
//     PRINT_PC    PC of the print point
//     PASS_PC     PC of the end-of-test point
//     FAIL_PC     PC of the failure trap
//     TIMEOUT_CYC RUN cycles before timeout
//     EDGE_MODE   1: capture once per arrival at PRINT_PC
//                 0: capture every cycle PC == PRINT_PC
// ---------------------------------------------------------------------------
module isa_test_monitor #(
    parameter int unsigned     PC_W        = 32,
    parameter int unsigned     CHAR_W      = 8,
    parameter int unsigned     BUF_DEPTH   = 16,
    parameter logic [PC_W-1:0] PRINT_PC    = 32'h0000_0014,
    parameter logic [PC_W-1:0] PASS_PC     = 32'h0000_001c,
    parameter logic [PC_W-1:0] FAIL_PC     = 32'hffff_fffc,
    parameter int unsigned     TIMEOUT_CYC = 1_000_000,
    parameter bit              EDGE_MODE   = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    isa_test_monitor_if.slave   bus
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_PASS    = 3'd2;
    localparam logic [2:0] ST_FAIL    = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;

    localparam int unsigned AW       = $clog2(BUF_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(BUF_DEPTH);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              prev_print;
    logic [31:0]       cycle_cnt;
    logic [15:0]       char_cnt;
    logic              overflow;

    logic [CHAR_W-1:0] mem [BUF_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    logic pc_print;
    logic pc_pass;
    logic pc_fail;
    logic in_run;
    logic capture;
    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic drop;
    logic tmo_hit;

    always_comb begin
        pc_print   = (bus.i_pc_debug == PRINT_PC);
        pc_pass    = (bus.i_pc_debug == PASS_PC);
        pc_fail    = (bus.i_pc_debug == FAIL_PC);
        in_run     = (state == ST_RUN);
        tmo_hit    = (cycle_cnt == TMO_LAST);

        // Edge mode suppresses repeat captures while a stalled pipeline
        // keeps the PC parked on the print routine.
        if (EDGE_MODE)
            capture = in_run && pc_print && !prev_print;
        else
            capture = in_run && pc_print;

        fifo_empty = (count == '0);
        fifo_full  = (count == FULL_CNT);
        pop        = bus.i_rd_en && !fifo_empty;
        // A pop in the same cycle frees the slot the push needs.
        push       = capture && (!fifo_full || pop);
        drop       = capture && fifo_full && !pop;
    end

    // -----------------------------------------------------------------------
    // Next state; a PC match takes priority over the timeout
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.i_en)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (pc_pass)
                    state_nxt = ST_PASS;
                else if (pc_fail)
                    state_nxt = ST_FAIL;
                else if (tmo_hit)
                    state_nxt = ST_TIMEOUT;
            end
            default: state_nxt = state;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control registers and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= ST_IDLE;
            prev_print <= 1'b0;
            cycle_cnt  <= '0;
            char_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_print <= pc_print;

            // The count stops at TIMEOUT_CYC-1, the value at which the
            // timeout fires, so it reads frozen after a timeout.
            if (in_run && !tmo_hit && (cycle_cnt != '1))
                cycle_cnt <= cycle_cnt + 32'd1;

            if (push && (char_cnt != '1))
                char_cnt <= char_cnt + 16'd1;

            if (drop)
                overflow <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Character FIFO (first-word fall-through)
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.i_io_ledr[CHAR_W-1:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.o_char      = mem[rd_ptr];
    assign bus.o_char_vld  = !fifo_empty;
    assign bus.o_overflow  = overflow;
    assign bus.o_state     = state;
    assign bus.o_done      = (state == ST_PASS) || (state == ST_FAIL) ||
                             (state == ST_TIMEOUT);
    assign bus.o_char_cnt  = char_cnt;
    assign bus.o_cycle_cnt = cycle_cnt;

endmodule
